// File: rtl/sync_token_sink_pkg.sv
// -----------------------------------------------------------------------------
// sync_token_sink_pkg
// Shared definitions for the clocked token sink at the exit of the asynchronous
// controller ring: FSM state encoding and default parameter values.
// -----------------------------------------------------------------------------
package sync_token_sink_pkg;

    // Handshake FSM: data channel phases first, then error channel phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for a data request, checks for room
        ST_DREL  = 2'd1,  // Lack high, waiting for Lreq to drop
        ST_EWAIT = 2'd2,  // waiting for the error-channel request
        ST_EREL  = 2'd3   // LEack high, waiting for LEreq to drop
    } sink_state_e;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_DEPTH       = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 16;

endpackage : sync_token_sink_pkg

// File: rtl/sync_token_sink_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// First-word fall-through FIFO, synchronous active-high reset.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   push_i, din_i       write strobe and data (accepted when not full, or when
//                       a pop happens in the same cycle)
//   pop_i               consume the head (ignored when empty)
//   dout_o              head entry, valid while empty_o=0
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries (log2(DEPTH)+1 bits)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sync_fifo
    import sync_token_sink_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH + 1,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

    // A pop frees the slot in the same cycle, so a full FIFO may still take
    // a push alongside a pop.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    // NOTE: every always_comb output gets a default first; otherwise a missed
    // branch infers a latch.
    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; only pointers and the
    // count define validity, and an unreset array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : sync_fifo

// File: rtl/sync_token_sink.sv
// -----------------------------------------------------------------------------
// sync_token_sink
// Clocked receiving end of the asynchronous controller ring. Terminates the
// 4-phase data channel (Lreq/Lack) and the error channel (LEreq/LEack), tags
// each token with an error flag (re-capturing data on a late sample) and
// buffers tokens toward a valid/ready consumer.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   Lreq / Lack         data channel request (async) / acknowledge
//   LEreq / LEack       error channel request (async) / acknowledge
//   ldata, lerr         bundled data and error bit
//   out_valid/ready     consumer handshake on the FIFO head
//   out_data, out_err   head token data and its re-capture flag
//   err_count           saturating count of tokens received with lerr=1
// -----------------------------------------------------------------------------
module sync_token_sink
    import sync_token_sink_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Lreq,
    output logic              Lack,
    input  logic              LEreq,
    output logic              LEack,
    input  logic [WIDTH-1:0]  ldata,
    input  logic              lerr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] ereq_sync_q;
    logic                   req_s;
    logic                   ereq_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync_q  <= '0;
            ereq_sync_q <= '0;
        end else begin
            req_sync_q  <= {req_sync_q[SYNC_STAGES-2:0], Lreq};
            ereq_sync_q <= {ereq_sync_q[SYNC_STAGES-2:0], LEreq};
        end
    end

    assign req_s  = req_sync_q[SYNC_STAGES-1];
    assign ereq_s = ereq_sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------- FSM
    sink_state_e      state_q;
    logic             lack_q;
    logic             leack_q;
    logic [WIDTH-1:0] hold_data_q;
    logic             hold_err_q;
    logic             push_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] err_cnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [PTR_W:0]   fifo_cnt;
    logic [WIDTH:0]   fifo_head;
    logic             fifo_pop;
    logic [PTR_W+1:0] occupancy;
    logic             has_room;

    assign err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;

    // Admitting a token reserves its slot until the push lands, so the push
    // out of EWAIT can never find the FIFO full. The only outstanding
    // reservation seen from IDLE is a push still in flight.
    assign occupancy = {1'b0, fifo_cnt} + {{(PTR_W+1){1'b0}}, push_q};
    assign has_room  = !fifo_full && (occupancy < (PTR_W+2)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lack_q      <= 1'b0;
            leack_q     <= 1'b0;
            hold_data_q <= '0;
            hold_err_q  <= 1'b0;
            push_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            push_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Holding Lack low while full is the only backpressure.
                    if (req_s && has_room) begin
                        hold_data_q <= ldata;
                        lack_q      <= 1'b1;
                        state_q     <= ST_DREL;
                    end
                end
                ST_DREL: begin
                    if (!req_s) begin
                        lack_q  <= 1'b0;
                        state_q <= ST_EWAIT;
                    end
                end
                ST_EWAIT: begin
                    // An early LEreq simply waits here in the synchronizer.
                    if (ereq_s) begin
                        hold_err_q <= lerr;
                        if (lerr) begin
                            hold_data_q <= ldata;
                            err_cnt_q   <= err_cnt_d;
                        end
                        push_q  <= 1'b1;
                        leack_q <= 1'b1;
                        state_q <= ST_EREL;
                    end
                end
                ST_EREL: begin
                    if (!ereq_s) begin
                        leack_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO
    assign fifo_pop = !fifo_empty && out_ready;

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_q),
        .din_i   ({hold_err_q, hold_data_q}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // ---------------------------------------------------------------- outputs
    assign Lack      = lack_q;
    assign LEack     = leack_q;
    assign out_valid = !fifo_empty;
    // Head fields are forced to zero when empty so stale RAM never shows.
    assign out_data  = fifo_empty ? '0 : fifo_head[WIDTH-1:0];
    assign out_err   = !fifo_empty && fifo_head[WIDTH];
    assign err_count = err_cnt_q;

endmodule : sync_token_sink
